// File: rtl/axi_write.sv
// axi_write: AXI4 write-channel master, one INCR burst in flight at a time.
// A command (address, beats-1) is latched, AW is issued, W beats are passed
// straight through from the data source, and the B response is reported back
// as a DONE pulse (with ERR when the slave signals SLVERR/DECERR).
module axi_write #(
   parameter int C_AXI_THREAD_ID_WIDTH = 1,
   parameter int C_AXI_ADDR_WIDTH      = 32,
   parameter int C_AXI_DATA_WIDTH      = 128
) (
   input  logic                               CLK,
   input  logic                               RST,
   // command
   input  logic [C_AXI_ADDR_WIDTH-1:0]        CMD_ADDR,
   input  logic [7:0]                         CMD_LEN,
   input  logic                               CMD_VALID,
   output logic                               CMD_READY,
   // data source
   input  logic [C_AXI_DATA_WIDTH-1:0]        WR_DATA,
   input  logic                               WR_VALID,
   output logic                               WR_READY,
   // status
   output logic                               BUSY,
   output logic                               DONE,
   output logic                               ERR,
   // AW channel
   output logic [C_AXI_THREAD_ID_WIDTH-1:0]   AXI_AWID,
   output logic [C_AXI_ADDR_WIDTH-1:0]        AXI_AWADDR,
   output logic [7:0]                         AXI_AWLEN,
   output logic [2:0]                         AXI_AWSIZE,
   output logic [1:0]                         AXI_AWBURST,
   output logic                               AXI_AWLOCK,
   output logic [3:0]                         AXI_AWCACHE,
   output logic [2:0]                         AXI_AWPROT,
   output logic [3:0]                         AXI_AWQOS,
   output logic                               AXI_AWUSER,
   output logic                               AXI_AWVALID,
   input  logic                               AXI_AWREADY,
   // W channel
   output logic [C_AXI_DATA_WIDTH-1:0]        AXI_WDATA,
   output logic [C_AXI_DATA_WIDTH/8-1:0]      AXI_WSTRB,
   output logic                               AXI_WLAST,
   output logic                               AXI_WUSER,
   output logic                               AXI_WVALID,
   input  logic                               AXI_WREADY,
   // B channel
   input  logic [C_AXI_THREAD_ID_WIDTH-1:0]   AXI_BID,
   input  logic [1:0]                         AXI_BRESP,
   input  logic                               AXI_BUSER,
   input  logic                               AXI_BVALID,
   output logic                               AXI_BREADY
);

   localparam int         STRB_WIDTH = C_AXI_DATA_WIDTH / 8;
   localparam logic [2:0] AXSIZE     = 3'($clog2(STRB_WIDTH));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t                      state_reg;
   logic [C_AXI_ADDR_WIDTH-1:0] addr_reg;
   logic [7:0]                  len_reg;
   logic [7:0]                  beat_cnt_reg;
   logic                        done_reg;
   logic                        err_reg;

   logic                        in_data;
   logic                        last_beat;
   logic                        w_fire;
   logic                        unused_inputs;

   assign in_data   = (state_reg == DATA);
   assign last_beat = in_data && (beat_cnt_reg == len_reg);
   // The handshake is seen exactly as the slave sees it: source valid gated by DATA.
   assign w_fire    = in_data && WR_VALID && AXI_WREADY;

   // Burst sequencing: command latch, AW issue, beat counting, B completion.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         len_reg      <= '0;
         beat_cnt_reg <= '0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (CMD_VALID) begin
                  addr_reg     <= CMD_ADDR;
                  len_reg      <= CMD_LEN;
                  beat_cnt_reg <= '0;
                  state_reg    <= ADDR;
               end
            end
            ADDR: begin
               if (AXI_AWREADY) begin
                  state_reg <= DATA;
               end
            end
            DATA: begin
               if (w_fire) begin
                  beat_cnt_reg <= beat_cnt_reg + 8'd1;
                  if (last_beat) begin
                     state_reg <= RESP;
                  end
               end
            end
            RESP: begin
               if (AXI_BVALID) begin
                  done_reg  <= 1'b1;
                  // BRESP[1] covers both SLVERR and DECERR; EXOKAY is not an error.
                  err_reg   <= AXI_BRESP[1];
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Handshake and status outputs decode straight from the state register.
   assign CMD_READY   = (state_reg == IDLE);
   assign BUSY        = (state_reg != IDLE);
   assign DONE        = done_reg;
   assign ERR         = err_reg;

   assign AXI_AWID    = '0;
   assign AXI_AWADDR  = addr_reg;
   assign AXI_AWLEN   = len_reg;
   assign AXI_AWSIZE  = AXSIZE;
   assign AXI_AWBURST = 2'b01;
   assign AXI_AWLOCK  = 1'b0;
   assign AXI_AWCACHE = 4'b0011;
   assign AXI_AWPROT  = 3'b000;
   assign AXI_AWQOS   = 4'b0000;
   assign AXI_AWUSER  = 1'b0;
   assign AXI_AWVALID = (state_reg == ADDR);

   // W is a pure pass-through; an early WR_VALID is simply held off until DATA.
   assign AXI_WDATA   = WR_DATA;
   assign AXI_WSTRB   = '1;
   assign AXI_WLAST   = last_beat;
   assign AXI_WUSER   = 1'b0;
   assign AXI_WVALID  = in_data && WR_VALID;
   assign WR_READY    = in_data && AXI_WREADY;

   assign AXI_BREADY  = (state_reg == RESP);

   // Response ID/user and the low BRESP bit carry nothing this master needs.
   assign unused_inputs = ^{AXI_BID, AXI_BUSER, AXI_BRESP[0]};

endmodule

// File: tb/tb_axi_write.sv
// tb_axi_write: directed bench for axi_write with a simple slave and data source.
module tb_axi_write;

   localparam int IW = 1;
   localparam int AW = 32;
   localparam int DW = 128;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [AW-1:0] CMD_ADDR = '0;
   logic [7:0]    CMD_LEN = '0;
   logic          CMD_VALID = 1'b0;
   logic          CMD_READY;
   logic [DW-1:0] WR_DATA = '0;
   logic          WR_VALID = 1'b0;
   logic          WR_READY;
   logic          BUSY, DONE, ERR;
   logic [IW-1:0] AXI_AWID;
   logic [AW-1:0] AXI_AWADDR;
   logic [7:0]    AXI_AWLEN;
   logic [2:0]    AXI_AWSIZE;
   logic [1:0]    AXI_AWBURST;
   logic          AXI_AWLOCK;
   logic [3:0]    AXI_AWCACHE;
   logic [2:0]    AXI_AWPROT;
   logic [3:0]    AXI_AWQOS;
   logic          AXI_AWUSER;
   logic          AXI_AWVALID;
   logic          AXI_AWREADY = 1'b1;
   logic [DW-1:0] AXI_WDATA;
   logic [DW/8-1:0] AXI_WSTRB;
   logic          AXI_WLAST, AXI_WUSER, AXI_WVALID;
   logic          AXI_WREADY = 1'b1;
   logic [IW-1:0] AXI_BID = '0;
   logic [1:0]    AXI_BRESP = 2'b00;
   logic          AXI_BUSER = 1'b0;
   logic          AXI_BVALID = 1'b0;
   logic          AXI_BREADY;

   always #5 CLK = ~CLK;

   axi_write #(
      .C_AXI_THREAD_ID_WIDTH(IW),
      .C_AXI_ADDR_WIDTH(AW),
      .C_AXI_DATA_WIDTH(DW)
   ) dut (
      .CLK(CLK), .RST(RST),
      .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
      .AXI_AWID(AXI_AWID), .AXI_AWADDR(AXI_AWADDR), .AXI_AWLEN(AXI_AWLEN),
      .AXI_AWSIZE(AXI_AWSIZE), .AXI_AWBURST(AXI_AWBURST), .AXI_AWLOCK(AXI_AWLOCK),
      .AXI_AWCACHE(AXI_AWCACHE), .AXI_AWPROT(AXI_AWPROT), .AXI_AWQOS(AXI_AWQOS),
      .AXI_AWUSER(AXI_AWUSER), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
      .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WLAST(AXI_WLAST),
      .AXI_WUSER(AXI_WUSER), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
      .AXI_BID(AXI_BID), .AXI_BRESP(AXI_BRESP), .AXI_BUSER(AXI_BUSER),
      .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY)
   );

   int assert_cnt = 0;
   int fail_cnt   = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      assert_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- monitor (negedge) ----------------
   int            cyc = 0;
   logic          w_hs = 1'b0, wlast_hs = 1'b0, b_hs = 1'b0;
   logic [DW-1:0] obs_data[$];
   logic          obs_last[$];
   int            obs_cyc[$];
   int            aw_hs_cnt = 0, aw_valid_cycles = 0, aw_unstable = 0;
   int            order_err = 0, ready_busy_err = 0, done_cnt = 0, err_cnt = 0, err_alone = 0;
   logic [AW-1:0] aw_hs_addr = '0, aw_prev_addr = '0;
   logic [7:0]    aw_hs_len = '0, aw_prev_len = '0;
   logic          aw_prev_valid = 1'b0;

   always @(negedge CLK) begin
      cyc++;
      w_hs     = AXI_WVALID && AXI_WREADY;
      wlast_hs = w_hs && AXI_WLAST;
      b_hs     = AXI_BVALID && AXI_BREADY;
      if (w_hs) begin
         obs_data.push_back(AXI_WDATA);
         obs_last.push_back(AXI_WLAST);
         obs_cyc.push_back(cyc);
      end
      if (AXI_AWVALID) begin
         aw_valid_cycles++;
         if (aw_prev_valid && (AXI_AWADDR !== aw_prev_addr || AXI_AWLEN !== aw_prev_len))
            aw_unstable++;
      end
      if (AXI_AWVALID && AXI_AWREADY) begin
         aw_hs_cnt++;
         aw_hs_addr = AXI_AWADDR;
         aw_hs_len  = AXI_AWLEN;
      end
      if (AXI_WVALID && AXI_AWVALID) order_err++;
      if (BUSY && CMD_READY) ready_busy_err++;
      if (DONE) done_cnt++;
      if (ERR) err_cnt++;
      if (ERR && !DONE) err_alone++;
      aw_prev_valid = AXI_AWVALID;
      aw_prev_addr  = AXI_AWADDR;
      aw_prev_len   = AXI_AWLEN;
   end

   // ---------------- data source and slave (posedge + 1) ----------------
   logic [DW-1:0] src_base = '0;
   int            src_len = 0, src_idx = 0;
   logic          src_pat = 1'b0, w_pat = 1'b0;
   logic [15:0]   vpat = 16'b1011_0110_1101_0011;
   logic [15:0]   rpat = 16'b0110_1101_1011_1001;
   logic [1:0]    next_bresp = 2'b00;

   always @(posedge CLK) begin
      #1;
      if (w_hs) src_idx++;
      if (src_idx >= src_len) WR_VALID = 1'b0;
      else if (!(WR_VALID && !w_hs)) WR_VALID = src_pat ? vpat[cyc % 16] : 1'b1;
      WR_DATA    = src_base + DW'(src_idx);
      AXI_WREADY = w_pat ? rpat[cyc % 16] : 1'b1;
      if (RST || b_hs) AXI_BVALID = 1'b0;
      if (wlast_hs) begin
         AXI_BVALID = 1'b1;
         AXI_BRESP  = next_bresp;
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic edge_drive();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_mon();
      obs_data.delete();
      obs_last.delete();
      obs_cyc.delete();
      aw_hs_cnt = 0; aw_valid_cycles = 0; aw_unstable = 0; order_err = 0;
      ready_busy_err = 0; done_cnt = 0; err_cnt = 0; err_alone = 0;
   endtask

   task automatic src_load(input logic [DW-1:0] base, input int n);
      src_base = base;
      src_len  = n;
      src_idx  = 0;
      WR_VALID = 1'b0;
   endtask

   task automatic send_cmd(input logic [AW-1:0] a, input logic [7:0] l);
      int n;
      edge_drive();
      CMD_ADDR = a; CMD_LEN = l; CMD_VALID = 1'b1;
      tick();
      n = 0;
      while (!CMD_READY && n < 500) begin
         tick();
         n++;
      end
      if (!CMD_READY) check("cmd_accept_timeout", DW'(CMD_READY), DW'(1));
      edge_drive();
      CMD_VALID = 1'b0;
   endtask

   task automatic wait_done(input logic [AW-1:0] a, output int lat, output logic err_seen);
      lat = 0;
      err_seen = 1'b0;
      do begin
         tick();
         lat++;
      end while (!DONE && lat < 3000);
      if (!DONE) check("done_timeout", DW'(DONE), DW'(1));
      else err_seen = ERR;
      $display("burst addr=0x%0h done after %0d cycles err=%0b beats=%0d", a, lat, err_seen, obs_data.size());
   endtask

   task automatic check_beats(input string tag, input logic [DW-1:0] base, input int n);
      check({tag, "_beats"}, DW'(obs_data.size()), DW'(n));
      for (int i = 0; i < n && i < obs_data.size(); i++) begin
         check({tag, "_data"}, obs_data[i], base + DW'(i));
         check({tag, "_last"}, DW'(obs_last[i]), DW'(i == n - 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int   lat;
      logic e;

      // reset state
      repeat (3) edge_drive();
      RST = 1'b0;
      tick();
      check("rst_cmd_ready", DW'(CMD_READY), DW'(1));
      check("rst_busy", DW'(BUSY), DW'(0));
      check("rst_done", DW'(DONE), DW'(0));
      check("rst_err", DW'(ERR), DW'(0));
      check("rst_awvalid", DW'(AXI_AWVALID), DW'(0));
      check("rst_wvalid", DW'(AXI_WVALID), DW'(0));
      check("rst_wlast", DW'(AXI_WLAST), DW'(0));
      check("rst_bready", DW'(AXI_BREADY), DW'(0));
      check("rst_awaddr", DW'(AXI_AWADDR), DW'(0));
      check("rst_awlen", DW'(AXI_AWLEN), DW'(0));
      check("awsize", DW'(AXI_AWSIZE), DW'(4));
      check("awburst", DW'(AXI_AWBURST), DW'(1));
      check("awcache", DW'(AXI_AWCACHE), DW'(3));
      check("wstrb", DW'(AXI_WSTRB), DW'(16'hFFFF));

      // single beat, all readies high
      clear_mon();
      src_load(128'hA5A5_0000_1111_2222_3333_4444_5555_0000, 1);
      send_cmd(32'h0000_1000, 8'd0);
      wait_done(32'h0000_1000, lat, e);
      check("single_latency", DW'(lat), DW'(4));
      check("single_err", DW'(e), DW'(0));
      tick();
      check("single_done_pulse", DW'(DONE), DW'(0));
      check("single_awaddr", DW'(aw_hs_addr), DW'(32'h1000));
      check("single_awlen", DW'(aw_hs_len), DW'(0));
      check_beats("single", 128'hA5A5_0000_1111_2222_3333_4444_5555_0000, 1);
      check("single_done_cnt", DW'(done_cnt), DW'(1));

      // full 256-beat burst, data 0..255
      clear_mon();
      src_load('0, 256);
      send_cmd(32'h0000_2000, 8'd255);
      wait_done(32'h0000_2000, lat, e);
      tick();
      check_beats("full", '0, 256);
      if (obs_cyc.size() == 256)
         check("full_throughput", DW'(obs_cyc[255] - obs_cyc[0]), DW'(255));
      check("full_done_cnt", DW'(done_cnt), DW'(1));

      // AW backpressure then patterned W handshakes
      clear_mon();
      AXI_AWREADY = 1'b0;
      src_pat = 1'b1;
      w_pat   = 1'b1;
      src_load(128'hDEAD_0000, 8);
      send_cmd(32'h0000_3000, 8'd7);
      repeat (5) edge_drive();
      AXI_AWREADY = 1'b1;
      wait_done(32'h0000_3000, lat, e);
      tick();
      src_pat = 1'b0;
      w_pat   = 1'b0;
      check("bp_aw_cycles", DW'(aw_valid_cycles), DW'(6));
      check("bp_aw_stable", DW'(aw_unstable), DW'(0));
      check("bp_awaddr", DW'(aw_hs_addr), DW'(32'h3000));
      check("bp_awlen", DW'(aw_hs_len), DW'(7));
      check_beats("bp", 128'hDEAD_0000, 8);
      check("bp_w_after_aw", DW'(order_err), DW'(0));

      // SLVERR response
      clear_mon();
      next_bresp = 2'b10;
      src_load(128'h4000, 4);
      send_cmd(32'h0000_4000, 8'd3);
      wait_done(32'h0000_4000, lat, e);
      check("slverr_err", DW'(e), DW'(1));
      tick();
      check("slverr_done_pulse", DW'(DONE), DW'(0));
      check("slverr_err_pulse", DW'(ERR), DW'(0));
      check("slverr_err_cnt", DW'(err_cnt), DW'(1));
      check("slverr_err_alone", DW'(err_alone), DW'(0));

      // EXOKAY response is not an error
      clear_mon();
      next_bresp = 2'b01;
      src_load(128'h4100, 4);
      send_cmd(32'h0000_4100, 8'd3);
      wait_done(32'h0000_4100, lat, e);
      check("exokay_err", DW'(e), DW'(0));
      tick();
      check("exokay_err_cnt", DW'(err_cnt), DW'(0));
      next_bresp = 2'b00;

      // command held valid while busy
      clear_mon();
      src_load(128'h5000, 3);
      edge_drive();
      CMD_ADDR = 32'h0000_5000; CMD_LEN = 8'd1; CMD_VALID = 1'b1;
      tick();
      check("busy_first_ready", DW'(CMD_READY), DW'(1));
      edge_drive();
      CMD_ADDR = 32'h0000_6000; CMD_LEN = 8'd0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!DONE && lat < 1000);
      check("busy_first_done", DW'(DONE), DW'(1));
      check("busy_ready_at_b1", DW'(CMD_READY), DW'(1));
      $display("burst addr=0x5000 done after %0d cycles (second command pending)", lat);
      edge_drive();
      CMD_VALID = 1'b0;
      tick();
      check("busy_second_awvalid", DW'(AXI_AWVALID), DW'(1));
      check("busy_second_awaddr", DW'(AXI_AWADDR), DW'(32'h6000));
      wait_done(32'h0000_6000, lat, e);
      tick();
      check("busy_ready_while_busy", DW'(ready_busy_err), DW'(0));
      check("busy_aw_count", DW'(aw_hs_cnt), DW'(2));
      check("busy_beats", DW'(obs_data.size()), DW'(3));
      for (int i = 0; i < 3 && i < obs_data.size(); i++)
         check("busy_data", obs_data[i], 128'h5000 + DW'(i));

      // reset in the middle of DATA after 3 of 8 beats
      clear_mon();
      src_load(128'h7000, 3);
      send_cmd(32'h0000_7000, 8'd7);
      lat = 0;
      while (obs_data.size() < 3 && lat < 200) begin
         tick();
         lat++;
      end
      tick();
      check("midrst_beats", DW'(obs_data.size()), DW'(3));
      check("midrst_busy", DW'(BUSY), DW'(1));
      edge_drive();
      RST = 1'b1;
      src_load('0, 0);
      edge_drive();
      RST = 1'b0;
      tick();
      check("midrst_awvalid", DW'(AXI_AWVALID), DW'(0));
      check("midrst_wvalid", DW'(AXI_WVALID), DW'(0));
      check("midrst_bready", DW'(AXI_BREADY), DW'(0));
      check("midrst_cmd_ready", DW'(CMD_READY), DW'(1));
      check("midrst_done", DW'(done_cnt), DW'(0));

      // a fresh command completes after the abandoned burst
      clear_mon();
      src_load(128'h8000, 2);
      send_cmd(32'h0000_8000, 8'd1);
      wait_done(32'h0000_8000, lat, e);
      tick();
      check("post_rst_err", DW'(e), DW'(0));
      check("post_rst_awaddr", DW'(aw_hs_addr), DW'(32'h8000));
      check_beats("post_rst", 128'h8000, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/axi_write.md
# axi_write

AXI4 write-channel master: the write-side companion to the team's AXI read master on the same interconnect port. It accepts one burst command (address, beat count) and a streaming data source, then drives the AW, W and B channels to a memory-mapped slave such as the DDR controller. Only one burst is in flight at a time, and completion and error status are reported to the issuing logic.

## Interface
Parameters:
- C_AXI_THREAD_ID_WIDTH, 1, width of AWID/BID
- C_AXI_ADDR_WIDTH, 32, byte address width
- C_AXI_DATA_WIDTH, 128, data width in bits; power of two, 32..1024

Ports:
- CLK  in  1  sole clock; everything is rising-edge.
- RST  in  1  reset, synchronous and active-high.
- CMD_ADDR  in  C_AXI_ADDR_WIDTH  burst start byte address
- CMD_LEN  in  8  beats minus 1 (0 = 1 beat, 255 = 256 beats)
- CMD_VALID / CMD_READY  in / out  1  command handshake
- WR_DATA  in  C_AXI_DATA_WIDTH  write beat data
- WR_VALID / WR_READY  in / out  1  data handshake
- BUSY  out  1  burst in progress (not IDLE)
- DONE  out  1  one-cycle pulse when B response is accepted
- ERR  out  1  one-cycle pulse, coincident with DONE, when BRESP[1]=1
- AXI_AWID  out  C_AXI_THREAD_ID_WIDTH  constant 0
- AXI_AWADDR  out  C_AXI_ADDR_WIDTH  registered CMD_ADDR
- AXI_AWLEN  out  8  registered CMD_LEN
- AXI_AWSIZE  out  3  constant log2(C_AXI_DATA_WIDTH/8)
- AXI_AWBURST  out  2  constant 2'b01 (INCR)
- AXI_AWLOCK  out  1  constant 0
- AXI_AWCACHE  out  4  constant 4'b0011
- AXI_AWPROT  out  3  constant 0
- AXI_AWQOS  out  4  constant 0
- AXI_AWUSER  out  1  constant 0
- AXI_AWVALID / AXI_AWREADY  out / in  1  address handshake
- AXI_WDATA  out  C_AXI_DATA_WIDTH  equals WR_DATA
- AXI_WSTRB  out  C_AXI_DATA_WIDTH/8  all ones
- AXI_WLAST  out  1  final beat of the burst
- AXI_WUSER  out  1  constant 0
- AXI_WVALID / AXI_WREADY  out / in  1  data handshake
- AXI_BID  in  C_AXI_THREAD_ID_WIDTH  ignored
- AXI_BRESP  in  2  write response
- AXI_BUSER  in  1  ignored
- AXI_BVALID / AXI_BREADY  in / out  1  response handshake

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: CMD_READY=1. When CMD_VALID is high, latch CMD_ADDR and CMD_LEN, clear the beat counter, and go to ADDR.
- ADDR: AXI_AWVALID=1, with AWADDR/AWLEN held stable. On AXI_AWREADY, go to DATA.
- DATA: pass-through with no buffering:
  - AXI_WVALID = WR_VALID
  - WR_READY = AXI_WREADY
  - AXI_WDATA = WR_DATA
- Beat counter (8 bits) increments on each W handshake. AXI_WLAST = (count == latched LEN), gated with DATA.
- When the handshake occurs with WLAST=1, go to RESP.
- RESP: AXI_BREADY=1. On AXI_BVALID, go to IDLE, pulse DONE next cycle, and pulse ERR too if BRESP is SLVERR/DECERR.
- Outside DATA, WR_READY=0 and AXI_WVALID=0. WR_VALID asserted early is held off, never dropped.
- W never precedes the AW handshake. The caller guarantees the burst does not cross a 4 KB boundary; the block does not split bursts.
- A CMD_VALID arriving while BUSY is not accepted (CMD_READY=0).

## Timing
- Reset values: state IDLE, CMD_READY=1, BUSY=0, DONE=0, ERR=0, AXI_AWVALID=0, AXI_WVALID=0, AXI_WLAST=0, AXI_BREADY=0, AXI_AWADDR=0, AXI_AWLEN=0, beat counter=0.
- Command accepted at edge t: AXI_AWVALID high from cycle t+1.
- AW handshake at edge a: AXI_WVALID may assert at a+1.
- Last W handshake at edge w: AXI_BREADY high from w+1.
- If BVALID is already high at w+1, the B handshake completes at that edge.
- B handshake at edge b: DONE/ERR high during b+1, and CMD_READY high during b+1.
- Back-to-back command minimum overhead: 3 idle cycles between bursts.
- Minimum single-beat latency, from command accept to DONE, with all readies high: 4 cycles.
- W throughput: 1 beat/cycle when WR_VALID and AXI_WREADY are both continuously high.
- AWVALID, and WVALID once asserted, stay high until their handshake. Both are protocol-compliant because they are sourced from stable state or from WR_VALID (the source must also hold).
- RST mid-burst: all valids and readies drop on the next cycle and the burst is abandoned. System-level reset of the slave is required.

## Test plan
- Single beat: ADDR=0x1000, LEN=0, all readies high. Expect AWADDR=0x1000, AWLEN=0, AWSIZE=4 (128-bit), one W beat with WLAST=1, DONE 4 cycles after accept, ERR=0.
- Full burst: LEN=255, continuous data 0..255. Expect 256 W beats in 256 cycles, WLAST only on beat 255, data order preserved, one DONE.
- Backpressure: AWREADY held low 5 cycles, then a random WREADY/WR_VALID pattern on LEN=7. Expect AWVALID held stable for 6 cycles, exactly 8 handshakes, no data loss or duplication, and WLAST on handshake 8.
- Error response: BRESP=2'b10 on LEN=3. Expect DONE and ERR pulsed together for 1 cycle. BRESP=2'b01 (EXOKAY) yields ERR=0.
- Command while busy: CMD_VALID held high during a burst. Expect CMD_READY=0 until b+1, then a second burst starting with AWVALID at b+2.
- Reset mid-DATA after 3 of 8 beats: expect AWVALID, WVALID and BREADY all 0 and CMD_READY=1 the cycle after RST. A new command then completes normally.
